// File: rtl/booth_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : booth_seq_ctrl
//  Description : Control sequencer for a radix-2 Booth multiplier datapath.
//                Loads M/Q, clears A and Q-1, then runs WIDTH test/add-sub/
//                shift iterations before strobing A and Q onto the outbus.
//  Revision    : 1.0  initial release
// ============================================================================
module booth_seq_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset,      // asynchronous, active-low
    input  logic             start,
    input  logic             q0,
    input  logic             q_m1,
    output logic             busy,
    output logic             done,
    output logic             load_m,
    output logic             load_q,
    output logic             clr_a,
    output logic             clr_q_m1,
    output logic             load_a,
    output logic             sel_sub,
    output logic             shift_en,
    output logic             out_a,
    output logic             out_q,
    output logic [CNT_W-1:0] iter
);

    // Last iteration index; SHIFT with this count leaves the loop.
    localparam logic [CNT_W-1:0] c_iter_last = CNT_W'(WIDTH - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD_M = 4'd1,
        S_LOAD_Q = 4'd2,
        S_TEST   = 4'd3,
        S_ADD    = 4'd4,
        S_SUB    = 4'd5,
        S_SHIFT  = 4'd6,
        S_OUT_A  = 4'd7,
        S_OUT_Q  = 4'd8,
        S_DONE   = 4'd9
    } state_t;

    // Registered strobe bundle; always equals the decode of r_state.
    typedef struct packed {
        logic busy;
        logic done;
        logic load_m;
        logic load_q;
        logic clr_a;
        logic clr_q_m1;
        logic load_a;
        logic sel_sub;
        logic shift_en;
        logic out_a;
        logic out_q;
    } outs_t;

    state_t           r_state;
    outs_t            r_outs;
    logic [CNT_W-1:0] r_iter;

    // Strobe decode for a given state. Loading the output register with the
    // decode of the next state keeps outputs Moore-style and glitch-free.
    function automatic outs_t f_decode(input state_t s);
        outs_t o;
        o          = '0;
        o.busy     = (s != S_IDLE);
        case (s)
            S_LOAD_M: o.load_m = 1'b1;
            S_LOAD_Q: begin
                o.load_q   = 1'b1;
                o.clr_a    = 1'b1;
                o.clr_q_m1 = 1'b1;
            end
            S_ADD:    o.load_a = 1'b1;
            S_SUB: begin
                o.load_a  = 1'b1;
                o.sel_sub = 1'b1;
            end
            S_SHIFT:  o.shift_en = 1'b1;
            S_OUT_A:  o.out_a    = 1'b1;
            S_OUT_Q:  o.out_q    = 1'b1;
            S_DONE:   o.done     = 1'b1;
            default:  ;
        endcase
        return o;
    endfunction

    // Sequencer: state, iteration count and registered strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_outs  <= '0;
            r_iter  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // start is only honoured here; elsewhere it is ignored.
                    if (start) begin
                        r_state <= S_LOAD_M;
                        r_outs  <= f_decode(S_LOAD_M);
                    end else begin
                        r_state <= S_IDLE;
                        r_outs  <= f_decode(S_IDLE);
                    end
                end
                S_LOAD_M: begin
                    r_state <= S_LOAD_Q;
                    r_outs  <= f_decode(S_LOAD_Q);
                end
                S_LOAD_Q: begin
                    r_iter  <= '0;
                    r_state <= S_TEST;
                    r_outs  <= f_decode(S_TEST);
                end
                S_TEST: begin
                    // Booth recoding of the current multiplier bit pair.
                    case ({q0, q_m1})
                        2'b10: begin
                            r_state <= S_SUB;
                            r_outs  <= f_decode(S_SUB);
                        end
                        2'b01: begin
                            r_state <= S_ADD;
                            r_outs  <= f_decode(S_ADD);
                        end
                        default: begin
                            r_state <= S_SHIFT;
                            r_outs  <= f_decode(S_SHIFT);
                        end
                    endcase
                end
                S_ADD, S_SUB: begin
                    r_state <= S_SHIFT;
                    r_outs  <= f_decode(S_SHIFT);
                end
                S_SHIFT: begin
                    // Count wraps naturally when WIDTH is a power of two.
                    r_iter <= r_iter + 1'b1;
                    if (r_iter == c_iter_last) begin
                        r_state <= S_OUT_A;
                        r_outs  <= f_decode(S_OUT_A);
                    end else begin
                        r_state <= S_TEST;
                        r_outs  <= f_decode(S_TEST);
                    end
                end
                S_OUT_A: begin
                    r_state <= S_OUT_Q;
                    r_outs  <= f_decode(S_OUT_Q);
                end
                S_OUT_Q: begin
                    r_state <= S_DONE;
                    r_outs  <= f_decode(S_DONE);
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_outs  <= f_decode(S_IDLE);
                end
                default: begin
                    r_state <= S_IDLE;
                    r_outs  <= f_decode(S_IDLE);
                end
            endcase
        end
    end

    assign busy     = r_outs.busy;
    assign done     = r_outs.done;
    assign load_m   = r_outs.load_m;
    assign load_q   = r_outs.load_q;
    assign clr_a    = r_outs.clr_a;
    assign clr_q_m1 = r_outs.clr_q_m1;
    assign load_a   = r_outs.load_a;
    assign sel_sub  = r_outs.sel_sub;
    assign shift_en = r_outs.shift_en;
    assign out_a    = r_outs.out_a;
    assign out_q    = r_outs.out_q;
    assign iter     = r_iter;

endmodule
`default_nettype wire
